// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encoding,
// register-index constants and the ID-stage operand match helper.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  // True when a producer register feeds an operand actually read by the ID instruction
  function automatic logic reg_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rt
  );
    logic hit;
    hit = 1'b0;
    if (r != ZERO_REG) begin
      hit = (r == rs) || (uses_rt && (r == rt));
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-low clear and a synchronous clear;
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear has priority, increment stops at all-ones
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: same-cycle stall, bubble, flush
// and freeze decisions, memory-wait tracking and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Start,
  input  logic             IDEX_MemRead_i,
  input  logic             IDEX_RegWrite_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic             EXMEM_MemRead_i,
  input  logic [4:0]       EXMEM_Rd_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             IFID_UsesRt_i,
  input  logic             Branch_i,
  input  logic             BranchTaken_i,
  input  logic             Jump_i,
  input  logic             MemBusy_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeFreeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            r_state;
  logic              r_timeout;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              w_idex_match;
  logic              w_exmem_match;
  logic              w_load_use;
  logic              w_br_dep;
  logic              w_redirect;
  logic              w_wait_clr;
  logic              w_wait_inc;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_idex_match  = reg_match(IDEX_Rd_i, IFID_Rs_i, IFID_Rt_i, IFID_UsesRt_i);
  assign w_exmem_match = reg_match(EXMEM_Rd_i, IFID_Rs_i, IFID_Rt_i, IFID_UsesRt_i);
  assign w_load_use    = IDEX_MemRead_i && w_idex_match;
  assign w_br_dep      = Branch_i && ((IDEX_RegWrite_i && w_idex_match) ||
                                      (EXMEM_MemRead_i && w_exmem_match));
  assign w_redirect    = BranchTaken_i || Jump_i;

  // Fixed-priority control decode; a dependent redirect waits until its operands are ready
  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    PipeFreeze_o = 1'b0;
    if (!Start) begin
      IFIDFlush_o  = 1'b1;
      IDEXBubble_o = 1'b1;
    end else if (MemBusy_i) begin
      PipeFreeze_o = 1'b1;
    end else if (w_load_use || w_br_dep) begin
      IDEXBubble_o = 1'b1;
    end else if (w_redirect) begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IFIDFlush_o = 1'b1;
    end else begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
    end
  end

  assign w_wait_clr  = (r_state == ST_RUN) && MemBusy_i;
  assign w_wait_inc  = (r_state == ST_MEMWAIT) && MemBusy_i;
  assign w_stall_inc = Start && !PCWrite_o;
  assign w_flush_inc = Start && IFIDFlush_o;

  // Memory-wait FSM and sticky timeout; timeout sets on the edge the wait count reaches TIMEOUT
  always_ff @(posedge Clk or negedge Start) begin
    if (!Start) begin
      r_state   <= ST_RUN;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (MemBusy_i) begin
            r_state <= ST_MEMWAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_MEMWAIT: begin
          if (MemBusy_i) begin
            r_state <= ST_MEMWAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
      if (w_wait_inc && (w_wait_cnt >= WAIT_LAST)) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  assign timeout_o = r_timeout;

  sat_counter #(.CNT_W(WAIT_W)) u_wait_cnt (
    .Clk     (Clk),
    .rst_n   (Start),
    .i_clr   (w_wait_clr),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk     (Clk),
    .rst_n   (Start),
    .i_clr   (1'b0),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk     (Clk),
    .rst_n   (Start),
    .i_clr   (1'b0),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt_o)
  );

endmodule
